buyruk_onbellek_denetleyici: RTL and testbench

//  Read-only, direct-mapped instruction cache controller; initiator side of wrapper_sram (149-bit entries).

---
 rtl/buyruk_onbellek_denetleyici.sv | 215 +++++++++++++++++++++
 tb/tb_buyruk_onbellek_denetleyici.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buyruk_onbellek_denetleyici.sv
// Direct-mapped, read-only instruction cache controller.
// Looks up {tag, line} entries in an external single-port SRAM wrapper,
// refills misses from a single-beat memory bus and keeps valid bits in flops.
// Optional hit/miss counters are enabled with the ONBELLEK_SAYAC_EN macro.
//
// Handshakes:
//   request  : a fetch is accepted on a rising edge where istek_gecerli_i and
//              istek_hazir_o are both high; istek_hazir_o never depends on
//              anything but state, reset and temizle_i.
//   response : yanit_gecerli_o is a one-cycle pulse with no backpressure;
//              yanit_veri_o holds its value until the next pulse.
//   memory   : bellek_istek_o is held until a rising edge with bellek_hazir_i;
//              the line then arrives on the first edge with bellek_gecerli_i.
module buyruk_onbellek_denetleyici #(
  parameter int ADRES_GENISLIK = 32,
  parameter int INDIS_GENISLIK = 7,
  parameter int SATIR_GENISLIK = 128
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        istek_gecerli_i,
  input  logic [ADRES_GENISLIK-1:0]   istek_adres_i,
  output logic                        istek_hazir_o,
  output logic                        yanit_gecerli_o,
  output logic [31:0]                 yanit_veri_o,
  input  logic                        temizle_i,
  output logic                        bellek_istek_o,
  output logic [ADRES_GENISLIK-1:0]   bellek_adres_o,
  input  logic                        bellek_hazir_i,
  input  logic                        bellek_gecerli_i,
  input  logic [SATIR_GENISLIK-1:0]   bellek_veri_i,
  output logic                        sram_en_o,
  output logic                        sram_wen_o,
  output logic [INDIS_GENISLIK-1:0]   sram_adres_o,
  output logic [ADRES_GENISLIK-INDIS_GENISLIK-4+SATIR_GENISLIK-1:0] sram_veri_o,
  input  logic [ADRES_GENISLIK-INDIS_GENISLIK-4+SATIR_GENISLIK-1:0] sram_obek_i
`ifdef ONBELLEK_SAYAC_EN
  ,
  output logic [31:0]                 isabet_sayisi_o,
  output logic [31:0]                 iska_sayisi_o
`endif
);

  localparam int ETIKET_GENISLIK = ADRES_GENISLIK - INDIS_GENISLIK - 4;
  localparam int OBEK_GENISLIK   = ETIKET_GENISLIK + SATIR_GENISLIK;
  localparam int SATIR_SAYISI    = 1 << INDIS_GENISLIK;

  localparam logic [2:0] BOSTA        = 3'd0;
  localparam logic [2:0] KARSILASTIR  = 3'd1;
  localparam logic [2:0] BELLEK_ISTEK = 3'd2;
  localparam logic [2:0] BELLEK_BEKLE = 3'd3;
  localparam logic [2:0] YAZ          = 3'd4;
  localparam logic [2:0] YANIT        = 3'd5;

  logic [2:0]                  durum_q, durum_d;
  logic [ADRES_GENISLIK-1:0]   adres_q, adres_d;
  logic [SATIR_GENISLIK-1:0]   satir_q, satir_d;
  logic [SATIR_SAYISI-1:0]     gecerli_q, gecerli_d;
  logic                        temizle_bekliyor_q, temizle_bekliyor_d;
  logic [31:0]                 yanit_veri_q, yanit_veri_d;

  logic [ETIKET_GENISLIK-1:0]  etiket;
  logic [INDIS_GENISLIK-1:0]   indis;
  logic [1:0]                  kelime;
  logic                        isabet;
  logic                        adres_unused;

  // Byte offset bits inside the word are never needed.
  assign adres_unused = ^adres_q[1:0];

  assign etiket = adres_q[ADRES_GENISLIK-1 -: ETIKET_GENISLIK];
  assign indis  = adres_q[INDIS_GENISLIK+3:4];
  assign kelime = adres_q[3:2];
  assign isabet = gecerli_q[indis] &&
                  (sram_obek_i[OBEK_GENISLIK-1:SATIR_GENISLIK] == etiket);

  assign yanit_veri_o = yanit_veri_q;

  // Pick one 32-bit word out of a 16-byte line.
  function automatic logic [31:0] kelime_sec(input logic [SATIR_GENISLIK-1:0] s,
                                             input logic [1:0] w);
    logic [31:0] k;
    case (w)
      2'd0:    k = s[31:0];
      2'd1:    k = s[63:32];
      2'd2:    k = s[95:64];
      default: k = s[127:96];
    endcase
    return k;
  endfunction

  // Next-state logic and all port decodes; outputs are idle unless the
  // current state asks for them.
  always_comb begin
    durum_d            = durum_q;
    adres_d            = adres_q;
    satir_d            = satir_q;
    gecerli_d          = gecerli_q;
    temizle_bekliyor_d = temizle_bekliyor_q | temizle_i;
    yanit_veri_d       = yanit_veri_q;

    istek_hazir_o   = 1'b0;
    yanit_gecerli_o = 1'b0;
    bellek_istek_o  = 1'b0;
    bellek_adres_o  = '0;
    sram_en_o       = 1'b0;
    sram_wen_o      = 1'b0;
    sram_adres_o    = '0;
    sram_veri_o     = '0;

    case (durum_q)
      BOSTA: begin
        if (temizle_bekliyor_q) begin
          // Flush drains here so an in-flight refill always completes first.
          gecerli_d          = '0;
          temizle_bekliyor_d = temizle_i;
        end else begin
          // A new flush pulse wins over a simultaneous request; reset keeps
          // the port quiet while asserted.
          istek_hazir_o = rst_i && !temizle_i;
          if (istek_gecerli_i && istek_hazir_o) begin
            adres_d      = istek_adres_i;
            sram_en_o    = 1'b1;
            sram_adres_o = istek_adres_i[INDIS_GENISLIK+3:4];
            durum_d      = KARSILASTIR;
          end
        end
      end
      KARSILASTIR: begin
        if (isabet) begin
          yanit_veri_d = kelime_sec(sram_obek_i[SATIR_GENISLIK-1:0], kelime);
          durum_d      = YANIT;
        end else begin
          durum_d      = BELLEK_ISTEK;
        end
      end
      BELLEK_ISTEK: begin
        bellek_istek_o = 1'b1;
        bellek_adres_o = {adres_q[ADRES_GENISLIK-1:4], 4'h0};
        if (bellek_hazir_i) durum_d = BELLEK_BEKLE;
      end
      BELLEK_BEKLE: begin
        if (bellek_gecerli_i) begin
          satir_d = bellek_veri_i;
          durum_d = YAZ;
        end
      end
      YAZ: begin
        sram_en_o        = 1'b1;
        sram_wen_o       = 1'b1;
        sram_adres_o     = indis;
        sram_veri_o      = {etiket, satir_q};
        gecerli_d[indis] = 1'b1;
        yanit_veri_d     = kelime_sec(satir_q, kelime);
        durum_d          = YANIT;
      end
      YANIT: begin
        yanit_gecerli_o = 1'b1;
        durum_d         = BOSTA;
      end
      default: begin
        durum_d = BOSTA;
      end
    endcase
  end

  // State, latched request, refill line, valid bits and response word.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q            <= BOSTA;
      adres_q            <= '0;
      satir_q            <= '0;
      gecerli_q          <= '0;
      temizle_bekliyor_q <= 1'b0;
      yanit_veri_q       <= '0;
    end else begin
      durum_q            <= durum_d;
      adres_q            <= adres_d;
      satir_q            <= satir_d;
      gecerli_q          <= gecerli_d;
      temizle_bekliyor_q <= temizle_bekliyor_d;
      yanit_veri_q       <= yanit_veri_d;
    end
  end

`ifdef ONBELLEK_SAYAC_EN
  logic [31:0] isabet_sayisi_q, isabet_sayisi_d;
  logic [31:0] iska_sayisi_q, iska_sayisi_d;

  // One count per tag compare decision; wraps naturally and ignores flushes.
  always_comb begin
    isabet_sayisi_d = isabet_sayisi_q;
    iska_sayisi_d   = iska_sayisi_q;
    if (durum_q == KARSILASTIR) begin
      if (isabet) isabet_sayisi_d = isabet_sayisi_q + 32'd1;
      else        iska_sayisi_d   = iska_sayisi_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      isabet_sayisi_q <= '0;
      iska_sayisi_q   <= '0;
    end else begin
      isabet_sayisi_q <= isabet_sayisi_d;
      iska_sayisi_q   <= iska_sayisi_d;
    end
  end

  assign isabet_sayisi_o = isabet_sayisi_q;
  assign iska_sayisi_o   = iska_sayisi_q;
`endif

endmodule

// File: tb/tb_buyruk_onbellek_denetleyici.sv
// Bench for buyruk_onbellek_denetleyici: stand-in SRAM wrapper, responsive
// memory driver and a reference model of cache contents (per-index valid,
// tag and line) that predicts hit/miss, latency, data and SRAM writes.
module tb_buyruk_onbellek_denetleyici;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          istek_gecerli_i;
  logic [31:0]   istek_adres_i;
  logic          istek_hazir_o;
  logic          yanit_gecerli_o;
  logic [31:0]   yanit_veri_o;
  logic          temizle_i;
  logic          bellek_istek_o;
  logic [31:0]   bellek_adres_o;
  logic          bellek_hazir_i;
  logic          bellek_gecerli_i;
  logic [127:0]  bellek_veri_i;
  logic          sram_en_o;
  logic          sram_wen_o;
  logic [6:0]    sram_adres_o;
  logic [148:0]  sram_veri_o;
  logic [148:0]  sram_obek_i;
`ifdef ONBELLEK_SAYAC_EN
  logic [31:0]   isabet_sayisi_o;
  logic [31:0]   iska_sayisi_o;
`endif

  buyruk_onbellek_denetleyici dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .istek_gecerli_i  (istek_gecerli_i),
    .istek_adres_i    (istek_adres_i),
    .istek_hazir_o    (istek_hazir_o),
    .yanit_gecerli_o  (yanit_gecerli_o),
    .yanit_veri_o     (yanit_veri_o),
    .temizle_i        (temizle_i),
    .bellek_istek_o   (bellek_istek_o),
    .bellek_adres_o   (bellek_adres_o),
    .bellek_hazir_i   (bellek_hazir_i),
    .bellek_gecerli_i (bellek_gecerli_i),
    .bellek_veri_i    (bellek_veri_i),
    .sram_en_o        (sram_en_o),
    .sram_wen_o       (sram_wen_o),
    .sram_adres_o     (sram_adres_o),
    .sram_veri_o      (sram_veri_o),
    .sram_obek_i      (sram_obek_i)
`ifdef ONBELLEK_SAYAC_EN
    ,
    .isabet_sayisi_o  (isabet_sayisi_o),
    .iska_sayisi_o    (iska_sayisi_o)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- SRAM wrapper stand-in ----------------
  logic [148:0] sram_mem [128];
  initial for (int i = 0; i < 128; i++) sram_mem[i] = '0;
  always @(posedge clk_i) begin
    if (sram_en_o) begin
      if (sram_wen_o) sram_mem[sram_adres_o] <= sram_veri_o;
      else            sram_obek_i <= sram_mem[sram_adres_o];
    end
  end

  logic [224:0] outs_all;
  assign outs_all = {istek_hazir_o, yanit_gecerli_o, yanit_veri_o, bellek_istek_o,
                     bellek_adres_o, sram_en_o, sram_wen_o, sram_adres_o, sram_veri_o};

  // ---------------- reference model / scoreboard ----------------
  int           vectors = 0;
  int           errors  = 0;
  bit           ref_valid [128];
  logic [20:0]  ref_tag   [128];
  logic [127:0] ref_line  [128];
  logic [31:0]  last_data;
  logic [31:0]  m_hit, m_miss;
  logic [31:0]  exp_q [$];

  function automatic logic [31:0] word_of(input logic [127:0] line, input int w);
    logic [127:0] t;
    t = line >> (32 * w);
    return t[31:0];
  endfunction

  task automatic model_flush();
    for (int i = 0; i < 128; i++) ref_valid[i] = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_i); #1;
      vectors++;
      if (yanit_gecerli_o !== 1'b0 || yanit_veri_o !== last_data || bellek_istek_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet: got vld=%b data=%h req=%b want vld=0 data=%h req=0",
                 yanit_gecerli_o, yanit_veri_o, bellek_istek_o, last_data);
      end
    end
  endtask

  // One fetch end to end. Entry and exit are 1 time unit after a rising edge;
  // exit is in the response cycle.
  task automatic fetch(input logic [31:0] addr, input bit flush_req, input bit flush_in_bekle,
                       input int acc_d, input int ret_d, output bit was_hit, output int wait_cyc);
    logic [20:0]  tag;
    int           idx, w, n, resp_n, req_cycles, acc_cnt, ret_cnt, wr_cnt, exp_n;
    bit           hs, exp_hit, got_resp, in_bekle, returned, flushed;
    logic [127:0] line_new;
    logic [31:0]  resp_data, exp_data;
    logic [6:0]   wr_idx;
    logic [148:0] wr_data;
    tag = addr[31:11];
    idx = int'(addr[10:4]);
    w   = int'(addr[3:2]);
    line_new = {$urandom, $urandom, $urandom, $urandom};
    wr_idx = '0; wr_data = '0; resp_data = '0; resp_n = 0;
    was_hit = 1'b0;

    istek_gecerli_i = 1'b1;
    istek_adres_i   = addr;
    wait_cyc = 0;
    hs = 1'b0;
    if (flush_req) begin
      temizle_i = 1'b1;
      #1;
      vectors++;
      if (istek_hazir_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_blocks_request: got hazir=%b want 0", istek_hazir_o);
      end
      model_flush();
      @(posedge clk_i); #1;
      temizle_i = 1'b0;
      wait_cyc++;
    end
    while (!hs && wait_cyc < 20) begin
      #1;
      if (istek_hazir_o === 1'b1) begin
        hs = 1'b1;
        vectors++;
        if (sram_en_o !== 1'b1 || sram_wen_o !== 1'b0 || sram_adres_o !== addr[10:4]) begin
          errors++;
          $display("FAIL sram_read: got en=%b wen=%b adr=%h want en=1 wen=0 adr=%h",
                   sram_en_o, sram_wen_o, sram_adres_o, addr[10:4]);
        end
      end
      @(posedge clk_i); #1;
      if (!hs) wait_cyc++;
      vectors++;
      if (yanit_gecerli_o !== 1'b0 || yanit_veri_o !== last_data) begin
        errors++;
        $display("FAIL response_hold: got vld=%b data=%h want vld=0 data=%h",
                 yanit_gecerli_o, yanit_veri_o, last_data);
      end
    end
    istek_gecerli_i = 1'b0;
    if (!hs) begin
      vectors++; errors++;
      $display("FAIL handshake_timeout: addr %h got no istek_hazir_o want handshake", addr);
      return;
    end

    exp_hit = ref_valid[idx] && (ref_tag[idx] == tag);
    if (exp_hit) m_hit++; else m_miss++;

    n = 1; got_resp = 0; req_cycles = 0; acc_cnt = 0; ret_cnt = 0; wr_cnt = 0;
    in_bekle = 0; returned = 0; flushed = 0;
    while (!got_resp && n < 100) begin
      if (yanit_gecerli_o === 1'b1) begin
        got_resp  = 1;
        resp_n    = n;
        resp_data = yanit_veri_o;
      end else begin
        if (sram_en_o === 1'b1 && sram_wen_o === 1'b1) begin
          wr_cnt++; wr_idx = sram_adres_o; wr_data = sram_veri_o;
        end
        bellek_hazir_i   = 1'b0;
        bellek_gecerli_i = 1'b0;
        bellek_veri_i    = '0;
        temizle_i        = 1'b0;
        if (bellek_istek_o === 1'b1) begin
          if (req_cycles == 0) begin
            vectors++;
            if (bellek_adres_o !== {addr[31:4], 4'h0}) begin
              errors++;
              $display("FAIL refill_addr: got %h want %h", bellek_adres_o, {addr[31:4], 4'h0});
            end
          end
          req_cycles++;
          if (acc_cnt == acc_d) begin bellek_hazir_i = 1'b1; in_bekle = 1; end
          else acc_cnt++;
        end else if (in_bekle && !returned) begin
          if (flush_in_bekle && !flushed) begin temizle_i = 1'b1; flushed = 1; end
          if (ret_cnt == ret_d) begin
            bellek_gecerli_i = 1'b1; bellek_veri_i = line_new; returned = 1;
          end else ret_cnt++;
        end else if (n == 1) begin
          // Stray line beat while comparing: must be ignored.
          bellek_gecerli_i = 1'($urandom_range(0, 1));
          bellek_veri_i    = {$urandom, $urandom, $urandom, $urandom};
        end
        @(posedge clk_i); #1;
        n++;
      end
    end
    bellek_hazir_i = 1'b0; bellek_gecerli_i = 1'b0; temizle_i = 1'b0;
    was_hit = (req_cycles == 0);

    if (!got_resp) begin
      vectors++; errors++;
      $display("FAIL response_timeout: addr %h got no yanit_gecerli_o want pulse", addr);
      return;
    end

    exp_data = exp_hit ? word_of(ref_line[idx], w) : word_of(line_new, w);
    exp_q.push_back(exp_data);
    exp_n = exp_hit ? 2 : 5 + acc_d + ret_d;

    vectors++;
    if (was_hit !== exp_hit) begin
      errors++;
      $display("FAIL hit_miss addr %h: got hit=%b want hit=%b", addr, was_hit, exp_hit);
    end
    vectors++;
    if (resp_n != exp_n) begin
      errors++;
      $display("FAIL latency addr %h: got %0d want %0d", addr, resp_n, exp_n);
    end
    vectors++;
    if (resp_data !== exp_q[0]) begin
      errors++;
      $display("FAIL data addr %h: got %h want %h", addr, resp_data, exp_q[0]);
    end
    void'(exp_q.pop_front());
    vectors++;
    if (wr_cnt != (exp_hit ? 0 : 1)) begin
      errors++;
      $display("FAIL sram_write_count addr %h: got %0d want %0d", addr, wr_cnt, exp_hit ? 0 : 1);
    end else if (!exp_hit) begin
      vectors++;
      if (wr_idx !== addr[10:4] || wr_data !== {tag, line_new}) begin
        errors++;
        $display("FAIL sram_write addr %h: got idx=%h data=%h want idx=%h data=%h",
                 addr, wr_idx, wr_data, addr[10:4], {tag, line_new});
      end
    end

    if (!exp_hit) begin
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tag;
      ref_line[idx]  = line_new;
    end
    if (flushed) model_flush();
    last_data = exp_data;
`ifdef ONBELLEK_SAYAC_EN
    vectors++;
    if (isabet_sayisi_o !== m_hit || iska_sayisi_o !== m_miss) begin
      errors++;
      $display("FAIL counters: got hit=%0d miss=%0d want hit=%0d miss=%0d",
               isabet_sayisi_o, iska_sayisi_o, m_hit, m_miss);
    end
`endif
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_i = 1'b0;
    istek_gecerli_i = 1'b0; istek_adres_i = '0; temizle_i = 1'b0;
    bellek_hazir_i = 1'b0; bellek_gecerli_i = 1'b0; bellek_veri_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    vectors++;
    if (outs_all !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", outs_all);
    end
    rst_i = 1'b1;
    model_flush();
    last_data = '0; m_hit = '0; m_miss = '0;
`ifdef ONBELLEK_SAYAC_EN
    vectors++;
    if (isabet_sayisi_o !== 32'd0 || iska_sayisi_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", isabet_sayisi_o, iska_sayisi_o);
    end
`endif
    #1;
    vectors++;
    if (istek_hazir_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b want 1", istek_hazir_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_directed();
    bit h; int wc;
    // cold miss, then hit in same line
    fetch(32'h0000_1004, 0, 0, 1, 2, h, wc);
    vectors++;
    if (h !== 1'b0) begin errors++; $display("FAIL cold_miss: got hit=%b want 0", h); end
    idle(2);
    fetch(32'h0000_100C, 0, 0, 0, 0, h, wc);
    vectors++;
    if (h !== 1'b1) begin errors++; $display("FAIL hit_100c: got hit=%b want 1", h); end
    // conflict on index 0
    idle(1);
    fetch(32'h0000_1800, 0, 0, 0, 1, h, wc);
    vectors++;
    if (h !== 1'b0) begin errors++; $display("FAIL conflict_1800: got hit=%b want 0", h); end
    fetch(32'h0000_1004, 0, 0, 2, 0, h, wc);
    vectors++;
    if (h !== 1'b0) begin errors++; $display("FAIL refetch_1004: got hit=%b want 0", h); end
  endtask

  task automatic test_back_to_back();
    bit h; int wc;
    fetch(32'h0000_1008, 0, 0, 0, 0, h, wc);
    vectors++;
    if (h !== 1'b1 || wc != 1) begin
      errors++; $display("FAIL b2b_first: got hit=%b wait=%0d want hit=1 wait=1", h, wc);
    end
    fetch(32'h0000_1000, 0, 0, 0, 0, h, wc);
    vectors++;
    if (h !== 1'b1 || wc != 1) begin
      errors++; $display("FAIL b2b_second: got hit=%b wait=%0d want hit=1 wait=1", h, wc);
    end
  endtask

  task automatic test_flush();
    bit h; int wc;
    idle(1);
    fetch(32'h0000_1004, 0, 0, 0, 0, h, wc);
    idle(1);
    fetch(32'h0000_1004, 1, 0, 1, 1, h, wc);
    vectors++;
    if (h !== 1'b0) begin errors++; $display("FAIL miss_after_flush: got hit=%b want 0", h); end
  endtask

  task automatic test_flush_refill();
    bit h; int wc;
    idle(1);
    fetch(32'h0000_2010, 0, 1, 1, 2, h, wc);
    idle(1);
    fetch(32'h0000_2010, 0, 0, 0, 0, h, wc);
    vectors++;
    if (h !== 1'b0) begin errors++; $display("FAIL flush_during_refill: got hit=%b want 0", h); end
  endtask

  task automatic test_reset_mid_refill();
    bit h, seen; int wc, k;
    idle(1);
    istek_gecerli_i = 1'b1;
    istek_adres_i   = 32'hFFFF_F008;
    seen = 0;
    for (k = 0; k < 10 && !seen; k++) begin
      #1;
      if (istek_hazir_o === 1'b1) seen = 1;
      @(posedge clk_i); #1;
    end
    istek_gecerli_i = 1'b0;
    seen = 0;
    for (k = 0; k < 10 && !seen; k++) begin
      if (bellek_istek_o === 1'b1) seen = 1;
      else begin @(posedge clk_i); #1; end
    end
    vectors++;
    if (!seen) begin errors++; $display("FAIL mid_refill_request: got no bellek_istek_o want 1"); end
    rst_i = 1'b0;
    #1;
    vectors++;
    if (outs_all !== '0) begin errors++; $display("FAIL mid_reset_outputs: got %h want 0", outs_all); end
`ifdef ONBELLEK_SAYAC_EN
    vectors++;
    if (isabet_sayisi_o !== 32'd0 || iska_sayisi_o !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_counters: got %0d/%0d want 0/0", isabet_sayisi_o, iska_sayisi_o);
    end
`endif
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    model_flush();
    last_data = '0; m_hit = '0; m_miss = '0;
    idle(6);
    fetch(32'hFFFF_F008, 0, 0, 0, 0, h, wc);
    vectors++;
    if (h !== 1'b0) begin errors++; $display("FAIL after_mid_reset: got hit=%b want 0", h); end
  endtask

  task automatic test_random();
    bit h; int wc;
    logic [31:0] a;
    bit fr, fb;
    for (int it = 0; it < 80; it++) begin
      a = {$urandom_range(1, 4) * 32'd2048} | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      fr = ($urandom_range(0, 9) == 0);
      fb = ($urandom_range(0, 9) == 0);
      if (fr || $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      fetch(a, fr, fb, $urandom_range(0, 3), $urandom_range(0, 3), h, wc);
    end
    idle(2);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_flush_refill();
    test_reset_mid_refill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
